alu_issue: RTL

- Decode/issue stage that builds the ALU operation code and operands the ALU consumes.
- Takes an RV32I instruction plus register-file read data and PC, and decodes it into aluOp, ASrc, BSrc and an illegal flag.
- Presents the result through a registered valid/ready interface with a 2-entry skid buffer, so upstream and downstream stall independently.
- Sits between the register-read stage and the execute stage holding the ALU.

---
 rtl/alu_issue.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: builds ALU op code and operands, presented through a 2-entry skid buffer.
// Optional macro ALU_ISSUE_CNT_EN adds issued-packet and stall-cycle counters.
module alu_issue #(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_aluop,
    output logic [XLEN-1:0] out_asrc,
    output logic [XLEN-1:0] out_bsrc,
    output logic            out_illegal,
    output logic [31:0]     issue_cnt,
    output logic [31:0]     stall_cnt
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    if (SKID_DEPTH != 2) begin : g_depth_unsupported
        $error("alu_issue supports only SKID_DEPTH == 2");
    end

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            ill;
    } pkt_t;

    // Illegal packets always carry op=ADD with zero operands, whatever the opcode.
    function automatic pkt_t decode(
        input logic [31:0]     instr,
        input logic [XLEN-1:0] rs1,
        input logic [XLEN-1:0] rs2,
        input logic [XLEN-1:0] pc
    );
        pkt_t            p;
        logic [6:0]      opcode;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm_i;
        logic [XLEN-1:0] imm_s;
        logic [XLEN-1:0] imm_u;
        logic [XLEN-1:0] shamt;
        opcode = instr[6:0];
        f3     = instr[14:12];
        f7     = instr[31:25];
        imm_i  = XLEN'($signed(instr[31:20]));
        imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
        imm_u  = XLEN'($signed({instr[31:12], 12'h000}));
        shamt  = XLEN'(instr[24:20]);
        p.op   = OP_ADD;
        p.a    = '0;
        p.b    = '0;
        p.ill  = 1'b0;
        case (opcode)
            OPC_R: begin
                if ((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
                    p.op = {f7[5], f3};
                    p.a  = rs1;
                    p.b  = rs2;
                end else begin
                    p.ill = 1'b1;
                end
            end
            OPC_I: begin
                if (f3 == 3'b001) begin
                    if (f7 == F7_BASE) begin
                        p.op = {1'b0, f3};
                        p.a  = rs1;
                        p.b  = shamt;
                    end else begin
                        p.ill = 1'b1;
                    end
                end else if (f3 == 3'b101) begin
                    if ((f7 == F7_BASE) || (f7 == F7_ALT)) begin
                        p.op = {f7[5], f3};
                        p.a  = rs1;
                        p.b  = shamt;
                    end else begin
                        p.ill = 1'b1;
                    end
                end else begin
                    p.op = {1'b0, f3};
                    p.a  = rs1;
                    p.b  = imm_i;
                end
            end
            OPC_LUI: begin
                p.b = imm_u;
            end
            OPC_AUIPC: begin
                p.a = pc;
                p.b = imm_u;
            end
            OPC_LOAD: begin
                p.a = rs1;
                p.b = imm_i;
            end
            OPC_STORE: begin
                p.a = rs1;
                p.b = imm_s;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000, 3'b001: begin
                        p.op = OP_SUB;
                        p.a  = rs1;
                        p.b  = rs2;
                    end
                    3'b100, 3'b101: begin
                        p.op = OP_SLT;
                        p.a  = rs1;
                        p.b  = rs2;
                    end
                    3'b110, 3'b111: begin
                        p.op = OP_SLTU;
                        p.a  = rs1;
                        p.b  = rs2;
                    end
                    default: begin
                        p.ill = 1'b1;
                    end
                endcase
            end
            default: begin
                p.ill = 1'b1;
            end
        endcase
        return p;
    endfunction

    pkt_t in_pkt_s;
    pkt_t main_q, main_d;
    pkt_t skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic in_fire_s;
    logic out_fire_s;

    // Decode the incoming instruction.
    always_comb begin
        in_pkt_s = decode(in_instr, in_rs1, in_rs2, in_pc);
    end

    // Buffer next state: main always holds the oldest packet, skid the younger one.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        out_fire_s = main_vld_q & out_ready;
        in_fire_s  = in_valid & ~skid_vld_q;
        if (out_fire_s) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (in_fire_s) begin
                main_d = in_pkt_s;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_fire_s) begin
            if (main_vld_q) begin
                skid_d     = in_pkt_s;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = in_pkt_s;
                main_vld_d = 1'b1;
            end
        end else begin
            main_vld_d = main_vld_q;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign in_ready    = ~skid_vld_q;
    assign out_valid   = main_vld_q;
    assign out_aluop   = main_q.op;
    assign out_asrc    = main_q.a;
    assign out_bsrc    = main_q.b;
    assign out_illegal = main_q.ill;

`ifdef ALU_ISSUE_CNT_EN
    logic [31:0] issue_cnt_q;
    logic [31:0] stall_cnt_q;

    // Issued-packet and output-stall counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (out_fire_s) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end else begin
                issue_cnt_q <= issue_cnt_q;
            end
            if (main_vld_q && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign issue_cnt = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule
